// File: rtl/tcvc_traffic_gen.sv
// Traffic generator: pushes a patterned word stream into a main FIFO, waits for
// it to settle, then drains the destination FIFOs until they have stayed empty.
module tcvc_traffic_gen #(
  parameter int BW    = 6,
  parameter int NDEST = 2,
  parameter int CNT_W = 8,
  parameter int GAP   = 10
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [BW-1:0]    seed,
  input  logic [CNT_W-1:0] num_words,
  input  logic             drain_en,
  input  logic             main_full,
  output logic             main_wr,
  output logic [BW-1:0]    main_data,
  input  logic [NDEST-1:0] dest_empty,
  output logic [NDEST-1:0] dest_rd,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_sent,
  output logic [CNT_W-1:0] words_read
);

  localparam int PW    = BW - 2;
  localparam int GW    = $clog2(GAP + 1);
  localparam int SUM_W = CNT_W + $clog2(NDEST + 1) + 1;
  localparam logic [BW-1:0]    LFSR_TAPS = {2'b11, {PW{1'b0}}};
  localparam logic [SUM_W-1:0] RD_MAX    = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {
    MODE_INC = 2'd0, MODE_LFSR = 2'd1, MODE_ALT = 2'd2, MODE_INC_ALIAS = 2'd3
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] read_q, read_d;
  logic [BW-1:0]    pat_q, pat_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [GW-1:0]    hold_q, hold_d;
  logic [SUM_W-1:0] rd_sum;

  // The pattern register always holds the word to be presented next.
  function automatic logic [BW-1:0] pat_load(input mode_e m, input logic [BW-1:0] s);
    logic [BW-1:0] r;
    case (m)
      MODE_LFSR: r = (s == '0) ? BW'(1) : s;
      MODE_ALT:  r = {2'b00, s[PW-1:0]};
      default:   r = s;
    endcase
    return r;
  endfunction

  function automatic logic [BW-1:0] pat_advance(input mode_e m, input logic [BW-1:0] p);
    logic [BW-1:0] r;
    case (m)
      MODE_LFSR: r = p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
      MODE_ALT:  r = (p[BW-1:BW-2] == 2'b11) ? {2'b00, PW'(p[PW-1:0] + PW'(1))}
                                             : {2'b11, p[PW-1:0]};
      default:   r = p + BW'(1);
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    sent_d  = sent_q;
    read_d  = read_q;
    pat_d   = pat_q;
    gap_d   = gap_q;
    hold_d  = hold_q;

    // Strobes are gated by reset so an aborting cycle never pushes or pops.
    main_wr = reset_L && (state_q == S_FILL) && !main_full && (sent_q < num_q);
    dest_rd = (reset_L && (state_q == S_DRAIN) && drain_en) ? ~dest_empty : '0;

    rd_sum = SUM_W'(read_q);
    for (int k = 0; k < NDEST; k++) begin
      rd_sum = rd_sum + SUM_W'(dest_rd[k]);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FILL;
          mode_d  = mode_e'(mode);
          num_d   = num_words;
          pat_d   = pat_load(mode_e'(mode), seed);
          sent_d  = '0;
          read_d  = '0;
        end
      end
      S_FILL: begin
        if (main_wr) begin
          sent_d = sent_q + CNT_W'(1);
          pat_d  = pat_advance(mode_q, pat_q);
        end
        if (sent_d >= num_q) begin
          state_d = S_WAIT;
          gap_d   = GW'(GAP - 1);
        end
      end
      S_WAIT: begin
        if (gap_q == '0) begin
          state_d = S_DRAIN;
          hold_d  = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_DRAIN: begin
        read_d = (rd_sum > RD_MAX) ? {CNT_W{1'b1}} : rd_sum[CNT_W-1:0];
        if (&dest_empty) begin
          if (hold_q == GW'(GAP - 1)) begin
            state_d = S_DONE;
          end else begin
            hold_d = hold_q + GW'(1);
          end
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_L) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_INC;
      num_q   <= '0;
      sent_q  <= '0;
      read_q  <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      read_q  <= read_d;
      pat_q   <= pat_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
    end
  end

  assign main_data  = pat_q;
  assign busy       = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign words_sent = sent_q;
  assign words_read = read_q;

endmodule

// File: tb/tb_tcvc_traffic_gen.sv
// Directed bench for tcvc_traffic_gen: table-driven FILL vectors plus
// hand-written WAIT, DRAIN, ALT, LFSR, reset and saturation sequences.
module tb_tcvc_traffic_gen;

  logic       clk;
  logic       reset_L;
  logic       start;
  logic [1:0] mode;
  logic [5:0] seed;
  logic [7:0] num_words;
  logic       drain_en;
  logic       main_full;
  logic       main_wr;
  logic [5:0] main_data;
  logic [1:0] dest_empty;
  logic [1:0] dest_rd;
  logic       busy;
  logic       done;
  logic [7:0] words_sent;
  logic [7:0] words_read;

  int n_checks = 0;
  int n_fail   = 0;

  tcvc_traffic_gen dut (
    .clk(clk), .reset_L(reset_L), .start(start), .mode(mode), .seed(seed),
    .num_words(num_words), .drain_en(drain_en), .main_full(main_full),
    .main_wr(main_wr), .main_data(main_data), .dest_empty(dest_empty),
    .dest_rd(dest_rd), .busy(busy), .done(done), .words_sent(words_sent),
    .words_read(words_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [5:0] seed;
    logic [7:0] num;
    logic       full;
    logic       exp_wr;
    logic [5:0] exp_data;
    logic       exp_busy;
    logic [7:0] exp_sent;
  } vec_t;

  typedef struct {
    logic [1:0] de;
    logic       en;
  } dvec_t;

  vec_t  tbl[8];
  dvec_t dseq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_L = 1'b0;
    start   = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return v[0] ? ((v >> 1) ^ 6'b110000) : (v >> 1);
  endfunction

  initial begin
    int          wait_cycles;
    bit          found;
    int          rd_model;
    logic [1:0]  exp_rd;
    logic [5:0]  m;
    logic [5:0]  alt_exp[4];
    logic [5:0]  lfsr_hand[4];

    alt_exp   = '{6'h00, 6'h30, 6'h01, 6'h31};
    lfsr_hand = '{6'h01, 6'h30, 6'h18, 6'h0C};

    //          start seed   num   full  wr  data   busy sent
    tbl[0] = '{1'b1, 6'h21, 8'd4, 1'b0, 1'b0, 6'h00, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 6'h21, 8'd4, 1'b0, 1'b1, 6'h21, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 6'h21, 8'd4, 1'b0, 1'b1, 6'h22, 1'b1, 8'd1};
    tbl[3] = '{1'b0, 6'h21, 8'd4, 1'b1, 1'b0, 6'h23, 1'b1, 8'd2};
    tbl[4] = '{1'b1, 6'h3F, 8'd1, 1'b1, 1'b0, 6'h23, 1'b1, 8'd2};
    tbl[5] = '{1'b0, 6'h21, 8'd4, 1'b1, 1'b0, 6'h23, 1'b1, 8'd2};
    tbl[6] = '{1'b0, 6'h21, 8'd4, 1'b0, 1'b1, 6'h23, 1'b1, 8'd2};
    tbl[7] = '{1'b0, 6'h21, 8'd4, 1'b0, 1'b1, 6'h24, 1'b1, 8'd3};

    dseq.push_back('{2'b01, 1'b1});
    dseq.push_back('{2'b10, 1'b1});
    dseq.push_back('{2'b11, 1'b1});
    dseq.push_back('{2'b00, 1'b0});
    dseq.push_back('{2'b01, 1'b0});
    dseq.push_back('{2'b10, 1'b1});
    dseq.push_back('{2'b00, 1'b1});
    for (int i = 0; i < 9; i++) dseq.push_back('{2'b11, 1'b1});
    dseq.push_back('{2'b10, 1'b1});
    for (int i = 0; i < 10; i++) dseq.push_back('{2'b11, 1'b1});

    reset_L    = 1'b0;
    start      = 1'b0;
    mode       = 2'd0;
    seed       = 6'h00;
    num_words  = 8'd0;
    drain_en   = 1'b1;
    main_full  = 1'b0;
    dest_empty = 2'b00;
    tick();
    tick();
    @(negedge clk);
    check("rst_main_wr", main_wr, 0);
    check("rst_main_data", main_data, 0);
    check("rst_dest_rd", dest_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_sent", words_sent, 0);
    check("rst_words_read", words_read, 0);
    tick();
    reset_L = 1'b1;

    // INC fill with a three-cycle main_full stall and an ignored mid-run start.
    for (int i = 0; i < 8; i++) begin
      start     = tbl[i].start;
      mode      = 2'd0;
      seed      = tbl[i].seed;
      num_words = tbl[i].num;
      main_full = tbl[i].full;
      @(negedge clk);
      check($sformatf("fill%0d_wr", i), main_wr, tbl[i].exp_wr);
      check($sformatf("fill%0d_data", i), main_data, tbl[i].exp_data);
      check($sformatf("fill%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("fill%0d_sent", i), words_sent, tbl[i].exp_sent);
      check($sformatf("fill%0d_rd", i), dest_rd, 0);
      tick();
    end
    start = 1'b0;

    // WAIT length: dest_rd stays low until DRAIN is entered.
    wait_cycles = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dest_rd != 2'b00) begin
        found = 1'b1;
      end else begin
        check("wait_main_wr", main_wr, 0);
        check("wait_busy", busy, 1);
        wait_cycles++;
        tick();
      end
    end
    check("wait_found_drain", found, 1);
    check("wait_len", wait_cycles, 10);
    check("wait_sent", words_sent, 4);
    check("drain0_rd", dest_rd, 2'b11);
    check("drain0_read", words_read, 0);
    tick();
    rd_model = 2;

    foreach (dseq[i]) begin
      dest_empty = dseq[i].de;
      drain_en   = dseq[i].en;
      @(negedge clk);
      exp_rd = dseq[i].en ? ~dseq[i].de : 2'b00;
      check($sformatf("drain%0d_rd", i), dest_rd, exp_rd);
      check($sformatf("drain%0d_read", i), words_read, rd_model);
      check($sformatf("drain%0d_done", i), done, 0);
      tick();
      rd_model += $countones(exp_rd);
    end
    @(negedge clk);
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_read_model", words_read, rd_model);
    check("done_read_hand", words_read, 8);
    check("done_rd_zero", dest_rd, 0);
    tick();
    tick();
    @(negedge clk);
    check("done_frozen_sent", words_sent, 4);
    check("done_frozen_read", words_read, 8);
    check("done_hold", done, 1);

    // ALT restart from DONE.
    tick();
    start = 1'b1; mode = 2'd2; seed = 6'h00; num_words = 8'd4;
    @(negedge clk);
    check("alt_start_done", done, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("alt%0d_wr", i), main_wr, 1);
      check($sformatf("alt%0d_data", i), main_data, alt_exp[i]);
      if (i == 0) check("alt_read_cleared", words_read, 0);
      tick();
    end
    @(negedge clk);
    check("alt_end_wr", main_wr, 0);
    check("alt_end_sent", words_sent, 4);

    // Reset mid-FILL at push 3, no resume, then a clean restart from seed.
    tick();
    pulse_reset();
    start = 1'b1; mode = 2'd0; seed = 6'h10; num_words = 8'd6;
    tick();
    start = 1'b0;
    @(negedge clk); check("rfill0_data", main_data, 6'h10);
    tick();
    @(negedge clk); check("rfill1_data", main_data, 6'h11);
    tick();
    reset_L = 1'b0;
    @(negedge clk);
    check("rcycle_no_push", main_wr, 0);
    tick();
    reset_L = 1'b1;
    @(negedge clk);
    check("rabort_wr", main_wr, 0);
    check("rabort_data", main_data, 0);
    check("rabort_busy", busy, 0);
    check("rabort_done", done, 0);
    check("rabort_sent", words_sent, 0);
    check("rabort_rd", dest_rd, 0);
    tick();
    @(negedge clk);
    check("rabort_no_resume", busy, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("restart_wr", main_wr, 1);
    check("restart_data", main_data, 6'h10);
    check("restart_sent", words_sent, 0);
    tick();
    pulse_reset();

    // LFSR with seed 0: full period of 63 non-zero words.
    start = 1'b1; mode = 2'd1; seed = 6'h00; num_words = 8'd63;
    tick();
    start = 1'b0;
    m = 6'h01;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      check($sformatf("lfsr%0d_wr", i), main_wr, 1);
      check($sformatf("lfsr%0d_data", i), main_data, m);
      check($sformatf("lfsr%0d_nonzero", i), main_data != 6'h00, 1);
      if (i < 4) check($sformatf("lfsr%0d_hand", i), main_data, lfsr_hand[i]);
      tick();
      m = lfsr_step(m);
    end
    @(negedge clk);
    check("lfsr_end_wr", main_wr, 0);
    check("lfsr_end_sent", words_sent, 63);
    check("lfsr_period", main_data, 6'h01);
    tick();
    pulse_reset();

    // num_words = 0: one FILL cycle without a push, then WAIT; then saturate words_read.
    start = 1'b1; mode = 2'd0; seed = 6'h05; num_words = 8'd0;
    dest_empty = 2'b00; drain_en = 1'b1;
    tick();
    start = 1'b0;
    wait_cycles = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dest_rd != 2'b00) begin
        found = 1'b1;
      end else begin
        check("zero_no_push", main_wr, 0);
        wait_cycles++;
        tick();
      end
    end
    check("zero_found_drain", found, 1);
    check("zero_fill_wait_len", wait_cycles, 11);
    for (int i = 0; i < 140; i++) tick();
    @(negedge clk);
    check("sat_read", words_read, 8'hFF);
    check("sat_sent", words_sent, 0);
    check("sat_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
